// File: rtl/pu_div_master_if.sv
// Host request/response and PU write/select/output-enable signals of pu_div_master.
// master: the pu_div_master side; slave: the host together with the PU.
interface pu_div_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ATTR_WIDTH = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic [DATA_WIDTH-1:0] req_numer;
  logic [DATA_WIDTH-1:0] req_denom;
  logic [1:0]            req_attr;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_quot;
  logic [DATA_WIDTH-1:0] resp_rem;
  logic                  resp_invalid;
  logic                  signal_wr;
  logic                  signal_sel;
  logic [DATA_WIDTH-1:0] pu_data_out;
  logic [ATTR_WIDTH:0]   pu_attr_out;
  logic                  res_select;
  logic                  signal_oe;
  logic [DATA_WIDTH-1:0] pu_data_in;
  logic [ATTR_WIDTH:0]   pu_attr_in;

  modport master (
    input  req_valid, req_numer, req_denom, req_attr, resp_ready, pu_data_in, pu_attr_in,
    output req_ready, resp_valid, resp_quot, resp_rem, resp_invalid,
           signal_wr, signal_sel, pu_data_out, pu_attr_out, res_select, signal_oe
  );

  modport slave (
    output req_valid, req_numer, req_denom, req_attr, resp_ready, pu_data_in, pu_attr_in,
    input  req_ready, resp_valid, resp_quot, resp_rem, resp_invalid,
           signal_wr, signal_sel, pu_data_out, pu_attr_out, res_select, signal_oe
  );
endinterface

// File: rtl/pu_div_master.sv
// Valid/ready front end that runs one divide on a pu_div unit over the write/select/oe bus.
// Optional PU_DIV_MASTER_ZERO_CHECK_EN: zero denominators are answered locally without PU traffic.
module pu_div_master #(
  parameter int DATA_WIDTH  = 32,
  parameter int ATTR_WIDTH  = 4,
  parameter int INVALID     = 0,
  parameter int WAIT_CYCLES = 6
) (
  input  logic            clk,
  input  logic            rst,
  pu_div_master_if.master bus
);
  localparam int CNT_W    = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam int CNT_LOAD = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

  typedef enum logic [3:0] {
    IDLE, WR_NUM, WR_DEN, WAIT, RD_Q0, RD_Q1, RD_R0, RD_R1, RESP
  } state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic                  rst_q;
  logic                  accept;
  logic                  zero_skip;
  logic [DATA_WIDTH-1:0] numer, denom;
  logic [1:0]            attr;
  logic                  acc_inv;
  logic [DATA_WIDTH-1:0] quot, rem;
  logic                  resp_inv;

`ifdef PU_DIV_MASTER_ZERO_CHECK_EN
  assign zero_skip = (bus.req_denom == '0);
`else
  assign zero_skip = 1'b0;
`endif

  // req_ready stays low for one extra cycle after reset is released
  assign accept = bus.req_valid && (state == IDLE) && !rst_q;

  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = zero_skip ? RESP : WR_NUM;
      WR_NUM:  state_nxt = WR_DEN;
      WR_DEN:  state_nxt = (WAIT_CYCLES == 0) ? RD_Q0 : WAIT;
      WAIT:    if (cnt == '0) state_nxt = RD_Q0;
      RD_Q0:   state_nxt = RD_Q1;
      RD_Q1:   state_nxt = RD_R0;
      RD_R0:   state_nxt = RD_R1;
      RD_R1:   state_nxt = RESP;
      RESP:    if (bus.resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready   = 1'b0;
    bus.resp_valid  = 1'b0;
    bus.signal_wr   = 1'b0;
    bus.signal_sel  = 1'b0;
    bus.pu_data_out = '0;
    bus.pu_attr_out = '0;
    bus.res_select  = 1'b0;
    bus.signal_oe   = 1'b0;
    case (state)
      IDLE: bus.req_ready = !rst_q;
      WR_NUM: begin
        bus.signal_wr            = 1'b1;
        bus.pu_data_out          = numer;
        bus.pu_attr_out[INVALID] = attr[0];
      end
      WR_DEN: begin
        bus.signal_wr            = 1'b1;
        bus.signal_sel           = 1'b1;
        bus.pu_data_out          = denom;
        bus.pu_attr_out[INVALID] = attr[1];
      end
      RD_Q0, RD_Q1: begin
        bus.signal_oe  = 1'b1;
        bus.res_select = 1'b1;
      end
      RD_R0, RD_R1: bus.signal_oe = 1'b1;
      RESP: bus.resp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == WR_DEN) begin
      cnt <= CNT_W'(CNT_LOAD);
    end else if (state == WAIT && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      numer <= bus.req_numer;
      denom <= bus.req_denom;
    end
  end

  // PU presents each result in the second oe cycle, so capture at the end of RD_x1
  always_ff @(posedge clk) begin
    if (rst) begin
      attr     <= '0;
      acc_inv  <= 1'b0;
      quot     <= '0;
      rem      <= '0;
      resp_inv <= 1'b0;
    end else begin
      if (accept) begin
        attr    <= bus.req_attr;
        acc_inv <= 1'b0;
        if (zero_skip) begin
          quot     <= '0;
          rem      <= bus.req_numer;
          resp_inv <= 1'b1;
        end
      end
      if (state == RD_Q1) begin
        quot    <= bus.pu_data_in;
        acc_inv <= bus.pu_attr_in[INVALID];
      end
      if (state == RD_R1) begin
        rem      <= bus.pu_data_in;
        resp_inv <= acc_inv | bus.pu_attr_in[INVALID] | attr[0] | attr[1];
      end
    end
  end

  assign bus.resp_quot    = quot;
  assign bus.resp_rem     = rem;
  assign bus.resp_invalid = resp_inv;
endmodule

// File: tb/tb_pu_div_master.sv
// Scoreboard bench for pu_div_master with an ideal registered PU model on each bus.
module tb_pu_div_master;
  localparam int DW  = 32;
  localparam int AW  = 4;
  localparam int INV = 0;
  localparam int WC  = 6;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pu_div_master_if #(.DATA_WIDTH(DW), .ATTR_WIDTH(AW)) bus ();
  pu_div_master_if #(.DATA_WIDTH(DW), .ATTR_WIDTH(AW)) bus0 ();

  pu_div_master #(.DATA_WIDTH(DW), .ATTR_WIDTH(AW), .INVALID(INV), .WAIT_CYCLES(WC))
    dut (.clk(clk), .rst(rst), .bus(bus));
  pu_div_master #(.DATA_WIDTH(DW), .ATTR_WIDTH(AW), .INVALID(INV), .WAIT_CYCLES(0))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));

  typedef struct {
    logic [DW-1:0] q;
    logic [DW-1:0] r;
    logic          inv;
  } exp_t;
  exp_t sb[$];

  function automatic logic [DW-1:0] pu_res(input logic [DW-1:0] n, input logic [DW-1:0] d,
                                           input logic sel_q);
    if (d == '0) return sel_q ? '1 : n;
    return sel_q ? n / d : n % d;
  endfunction

  function automatic logic [AW:0] pu_flag(input logic ni, input logic di, input logic [DW-1:0] d);
    logic [AW:0] f;
    f = '0;
    f[INV] = ni | di | (d == '0);
    return f;
  endfunction

  // Ideal PU: operands latched on wr, result registered on each oe cycle
  logic [DW-1:0] pn, pd, pn0, pd0;
  logic          pni, pdi, pni0, pdi0;
  always @(posedge clk) begin
    if (bus.signal_wr) begin
      if (bus.signal_sel) begin pd <= bus.pu_data_out; pdi <= bus.pu_attr_out[INV]; end
      else                begin pn <= bus.pu_data_out; pni <= bus.pu_attr_out[INV]; end
    end
    if (bus.signal_oe) begin
      bus.pu_data_in <= pu_res(pn, pd, bus.res_select);
      bus.pu_attr_in <= pu_flag(pni, pdi, pd);
    end
  end
  always @(posedge clk) begin
    if (bus0.signal_wr) begin
      if (bus0.signal_sel) begin pd0 <= bus0.pu_data_out; pdi0 <= bus0.pu_attr_out[INV]; end
      else                 begin pn0 <= bus0.pu_data_out; pni0 <= bus0.pu_attr_out[INV]; end
    end
    if (bus0.signal_oe) begin
      bus0.pu_data_in <= pu_res(pn0, pd0, bus0.res_select);
      bus0.pu_attr_in <= pu_flag(pni0, pdi0, pd0);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit zero_path(input logic [DW-1:0] d);
    bit z;
    z = 1'b0;
`ifdef PU_DIV_MASTER_ZERO_CHECK_EN
    z = (d == '0);
`endif
    return z;
  endfunction

  task automatic push_exp(input logic [DW-1:0] n, input logic [DW-1:0] d, input logic [1:0] a);
    exp_t e;
    e.q   = (d == '0) ? '1 : n / d;
    e.r   = (d == '0) ? n : n % d;
    e.inv = (a != 2'b00) || (d == '0);
    if (zero_path(d)) e.q = '0;
    sb.push_back(e);
  endtask

  task automatic sb_compare(input string tag, input logic [DW-1:0] q, input logic [DW-1:0] r,
                            input logic inv);
    exp_t e;
    check({tag, " sb_pending"}, 64'(sb.size() > 0), 64'(1));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, " quot"}, 64'(q), 64'(e.q));
      check({tag, " rem"}, 64'(r), 64'(e.r));
      check({tag, " invalid"}, 64'(inv), 64'(e.inv));
    end
  endtask

  // Called at a negedge; returns at the negedge after the response handshake.
  task automatic txn(input string tag, input logic [DW-1:0] n, input logic [DW-1:0] d,
                     input logic [1:0] a, input int hold);
    int g, rel, wrs, oes, wr_first, oe_first, ov, bad_hold;
    logic [DW-1:0] d1, d2;
    logic a1, a2;
    bit skip;
    skip = zero_path(d);
    g = 0;
    while (!bus.req_ready && g < 40) begin @(negedge clk); g++; end
    check({tag, " req_ready"}, 64'(bus.req_ready), 64'(1));
    bus.req_numer  = n;
    bus.req_denom  = d;
    bus.req_attr   = a;
    bus.req_valid  = 1'b1;
    bus.resp_ready = (hold == 0);
    acc_cyc = cyc;
    push_exp(n, d, a);
    rel = 0; wrs = 0; oes = 0; wr_first = -1; oe_first = -1; ov = 0;
    d1 = '0; d2 = '0; a1 = 1'b0; a2 = 1'b0;
    do begin
      @(negedge clk);
      rel++;
      bus.req_valid = 1'b0;
      bus.req_numer = $urandom;
      bus.req_denom = $urandom;
      bus.req_attr  = 2'($urandom);
      if (bus.signal_wr) begin
        wrs++;
        if (wr_first < 0) wr_first = rel;
        if (bus.signal_sel) begin d2 = bus.pu_data_out; a2 = bus.pu_attr_out[INV]; end
        else                begin d1 = bus.pu_data_out; a1 = bus.pu_attr_out[INV]; end
      end
      if (bus.signal_oe) begin
        oes++;
        if (oe_first < 0) oe_first = rel;
      end
      if (bus.signal_wr && bus.signal_oe) ov++;
    end while (!bus.resp_valid && rel < 60);
    check({tag, " resp_cycle"}, 64'(rel), 64'(skip ? 1 : 7 + WC));
    check({tag, " wr_count"}, 64'(wrs), 64'(skip ? 0 : 2));
    check({tag, " wr_first"}, 64'(wr_first), 64'(skip ? -1 : 1));
    check({tag, " wr_numer"}, 64'(d1), 64'(skip ? '0 : n));
    check({tag, " wr_denom"}, 64'(d2), 64'(skip ? '0 : d));
    check({tag, " wr_attr"}, 64'({a2, a1}), 64'(skip ? 2'b00 : a));
    check({tag, " oe_first"}, 64'(oe_first), 64'(skip ? -1 : 3 + WC));
    check({tag, " oe_count"}, 64'(oes), 64'(skip ? 0 : 4));
    check({tag, " wr_oe_excl"}, 64'(ov), 64'(0));
    if (hold > 0) begin
      bad_hold = 0;
      for (int i = 0; i < hold; i++) begin
        bus.req_valid = 1'b1;
        @(negedge clk);
        if (!bus.resp_valid || bus.req_ready || bus.signal_wr || bus.signal_oe) bad_hold++;
        if (sb.size() > 0 && (bus.resp_quot !== sb[0].q || bus.resp_rem !== sb[0].r ||
                              bus.resp_invalid !== sb[0].inv)) bad_hold++;
      end
      check({tag, " hold"}, 64'(bad_hold), 64'(0));
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    sb_compare(tag, bus.resp_quot, bus.resp_rem, bus.resp_invalid);
    @(negedge clk);
    check({tag, " post_idle"}, 64'({bus.req_ready, bus.resp_valid}), 64'(2'b10));
  endtask

  initial begin
    int t0, g, rel, oe_first, bad;
    logic [DW-1:0] rn, rd;
    rst = 1'b1;
    bus.req_valid = 1'b0;  bus.req_numer = '0;  bus.req_denom = '0;  bus.req_attr = '0;
    bus.resp_ready = 1'b1;
    bus0.req_valid = 1'b0; bus0.req_numer = '0; bus0.req_denom = '0; bus0.req_attr = '0;
    bus0.resp_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("reset ctl", 64'({bus.req_ready, bus.resp_valid, bus.resp_invalid, bus.signal_wr,
                            bus.signal_sel, bus.res_select, bus.signal_oe, bus.pu_attr_out}), 64'(0));
    check("reset data", 64'({bus.resp_quot, bus.resp_rem}), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    check("reset release ready", 64'(bus.req_ready), 64'(1));

    txn("div100_7", 100, 7, 2'b00, 0);
    t0 = acc_cyc;
    txn("b2b", 1000, 33, 2'b00, 0);
    check("throughput", 64'(acc_cyc - t0), 64'(8 + WC));
    txn("backpressure", 12345, 100, 2'b00, 5);
    txn("denom_flag", 50, 5, 2'b10, 0);
    txn("numer_flag", 77, 8, 2'b01, 0);
    txn("zero_denom", 9, 0, 2'b00, 0);

    // Abort a request while it sits in WAIT
    bus.req_numer = 11; bus.req_denom = 4; bus.req_attr = 2'b00; bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort ctl", 64'({bus.req_ready, bus.resp_valid, bus.resp_invalid, bus.signal_wr,
                            bus.signal_sel, bus.res_select, bus.signal_oe, bus.pu_attr_out}), 64'(0));
    check("abort data", 64'({bus.resp_quot, bus.resp_rem}), 64'(0));
    check("abort pu_data_out", 64'(bus.pu_data_out), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    check("abort ready", 64'(bus.req_ready), 64'(1));
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.resp_valid || bus.signal_wr || bus.signal_oe) bad++;
    end
    check("abort dropped", 64'(bad), 64'(0));
    txn("after_rst", 20, 3, 2'b00, 0);

    for (int k = 0; k < 3; k++) begin
      rn = $urandom;
      rd = $urandom_range(1, 5000);
      txn("random", rn, rd, 2'($urandom), 0);
    end

    // WAIT_CYCLES = 0 instance
    g = 0;
    while (!bus0.req_ready && g < 40) begin @(negedge clk); g++; end
    check("w0 req_ready", 64'(bus0.req_ready), 64'(1));
    bus0.req_numer = 7; bus0.req_denom = 7; bus0.req_attr = 2'b00; bus0.req_valid = 1'b1;
    push_exp(7, 7, 2'b00);
    rel = 0;
    oe_first = -1;
    do begin
      @(negedge clk);
      rel++;
      bus0.req_valid = 1'b0;
      if (bus0.signal_oe && oe_first < 0) oe_first = rel;
    end while (!bus0.resp_valid && rel < 30);
    check("w0 oe_first", 64'(oe_first), 64'(3));
    check("w0 resp_cycle", 64'(rel), 64'(7));
    sb_compare("w0", bus0.resp_quot, bus0.resp_rem, bus0.resp_invalid);
    @(negedge clk);
    check("w0 post_idle", 64'({bus0.req_ready, bus0.resp_valid}), 64'(2'b10));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
